// File: rtl/nios_system_sprite_status_in.sv
// ============================================================================
// nios_system_sprite_status_in
// Avalon-MM status input port with sticky edge capture and a maskable IRQ.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nios_system_sprite_status_in #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] d_sync;
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] ev_armed;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr_en;
  logic             unused_wdata;

  assign d_sync       = sync_q[SYNC_STAGES-1];
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      d_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      d_prev <= d_sync;
    end
  end

  // Edges are ignored until the synchronizer and d_prev hold real samples,
  // so an input already high at reset release is not seen as a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_COUNT) begin
      arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign armed = (arm_cnt == ARM_COUNT);
  assign rise  = d_sync & ~d_prev;
  assign fall  = ~d_sync & d_prev;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign ev = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign ev = fall;
    end else begin : g_any
      assign ev = rise | fall;
    end
  endgenerate

  assign ev_armed = ev & {WIDTH{armed}};
  assign clr      = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      // A new event outranks a simultaneous clear so no edge is lost.
      edge_capture <= (edge_capture & ~clr) | ev_armed;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = d_sync;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

`default_nettype wire
